// File: rtl/clock_pkg.sv
// Shared types and constants for the reference-clock recovery loop.
package clock_pkg;
  localparam int NCO_W = 16;
  localparam logic [NCO_W-1:0] PHASE_HALF    = 16'h8000;
  localparam logic [NCO_W-1:0] PHASE_QUARTER = 16'h4000;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    LOCKED  = 2'd1,
    NOREF   = 2'd2
  } rec_state_t;
endpackage

// File: rtl/ref_edge_sync.sv
// Two-flop synchronizer for the asynchronous reference plus a one-cycle
// rising-edge pulse; reset is synchronous and active-low.
module ref_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic ref_in,
  output logic edge_pulse
);
  logic meta_reg, sync_reg, prev_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= ref_in;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign edge_pulse = sync_reg & ~prev_reg;
endmodule

// File: rtl/clock_recover.sv
// NCO locked to an external reference by a PI phase loop, with lock/NOREF FSM.
// Optional quadrature output enabled by defining CLOCK_RECOVER_QUAD_EN.
module clock_recover
  import clock_pkg::*;
#(
  parameter int INC_INIT   = 3640,
  parameter int INC_MIN    = 1024,
  parameter int INC_MAX    = 4096,
  parameter int KP_SHIFT   = 3,
  parameter int KI_SHIFT   = 8,
  parameter int LOCK_TOL   = 2048,
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_COUNT = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ref_in,
  output logic             clk_out,
  output logic             clk_q,
  output logic [NCO_W-1:0] freq_word,
  output logic [NCO_W-1:0] phase_err,
  output logic             locked
);
  localparam logic signed [18:0] SUM_INIT = 19'(INC_INIT);
  localparam logic signed [18:0] SUM_MAX  = 19'(INC_MAX);
  localparam logic signed [18:0] SUM_MIN  = 19'(INC_MIN);
  localparam logic signed [17:0] INTEG_HI = 18'(INC_MAX - INC_INIT);
  localparam logic signed [17:0] INTEG_LO = 18'(INC_MIN - INC_INIT);

  rec_state_t              state_reg, state_next;
  logic [NCO_W-1:0]        acc_reg, acc_next;
  logic [NCO_W-1:0]        freq_word_reg, freq_word_next;
  logic [NCO_W-1:0]        phase_err_reg, phase_err_next;
  logic signed [17:0]      integ_reg, integ_next;
  logic [4:0]              edge_cnt_reg, edge_cnt_next;
  logic [8:0]              idle_cnt_reg, idle_cnt_next;
  logic                    edge_pulse;
  logic signed [NCO_W-1:0] err, err_kp, err_ki;
  logic [NCO_W:0]          err_abs;
  logic                    in_tol;
  logic signed [17:0]      integ_sum, integ_clamped;
  logic signed [18:0]      freq_sum;
  logic [NCO_W-1:0]        freq_sat;

  ref_edge_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .ref_in     (ref_in),
    .edge_pulse (edge_pulse)
  );

  // Positive error means the NCO phase is ahead of the reference edge.
  assign err     = $signed(acc_reg - PHASE_HALF);
  assign err_kp  = err >>> KP_SHIFT;
  assign err_ki  = err >>> KI_SHIFT;
  assign err_abs = err[NCO_W-1] ? (17'd0 - {1'b1, err}) : {1'b0, err};
  assign in_tol  = err_abs < 17'(LOCK_TOL);

  // Integrator is pinned to the clamp-equivalent value whenever the word saturates.
  always_comb begin
    integ_sum     = integ_reg - {{2{err_ki[NCO_W-1]}}, err_ki};
    freq_sum      = {integ_sum[17], integ_sum} + SUM_INIT;
    freq_sat      = freq_sum[NCO_W-1:0];
    integ_clamped = integ_sum;
    if (freq_sum > SUM_MAX) begin
      freq_sat      = 16'(INC_MAX);
      integ_clamped = INTEG_HI;
    end else if (freq_sum < SUM_MIN) begin
      freq_sat      = 16'(INC_MIN);
      integ_clamped = INTEG_LO;
    end
  end

  always_comb begin
    state_next     = state_reg;
    edge_cnt_next  = edge_cnt_reg;
    idle_cnt_next  = idle_cnt_reg;
    acc_next       = acc_reg + freq_word_reg;
    integ_next     = integ_reg;
    freq_word_next = freq_word_reg;
    phase_err_next = phase_err_reg;
    if (edge_pulse) begin
      idle_cnt_next = '0;
      if (state_reg == NOREF) begin
        state_next    = ACQUIRE;
        edge_cnt_next = '0;
      end else begin
        phase_err_next = err;
        integ_next     = integ_clamped;
        freq_word_next = freq_sat;
        acc_next       = acc_reg + freq_word_reg - $unsigned(err_kp);
        case (state_reg)
          ACQUIRE: begin
            if (!in_tol) begin
              edge_cnt_next = '0;
            end else if (edge_cnt_reg == 5'(LOCK_COUNT - 1)) begin
              state_next    = LOCKED;
              edge_cnt_next = '0;
            end else begin
              edge_cnt_next = edge_cnt_reg + 5'd1;
            end
          end
          LOCKED: begin
            if (in_tol) begin
              edge_cnt_next = '0;
            end else if (edge_cnt_reg == 5'(LOSS_COUNT - 1)) begin
              state_next    = ACQUIRE;
              edge_cnt_next = '0;
            end else begin
              edge_cnt_next = edge_cnt_reg + 5'd1;
            end
          end
          default: ;
        endcase
      end
    end else if (state_reg != NOREF) begin
      if (idle_cnt_reg == 9'(TIMEOUT - 1)) begin
        state_next    = NOREF;
        idle_cnt_next = 9'(TIMEOUT);
        edge_cnt_next = '0;
      end else begin
        idle_cnt_next = idle_cnt_reg + 9'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ACQUIRE;
      acc_reg       <= '0;
      integ_reg     <= '0;
      freq_word_reg <= 16'(INC_INIT);
      phase_err_reg <= '0;
      edge_cnt_reg  <= '0;
      idle_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      integ_reg     <= integ_next;
      freq_word_reg <= freq_word_next;
      phase_err_reg <= phase_err_next;
      edge_cnt_reg  <= edge_cnt_next;
      idle_cnt_reg  <= idle_cnt_next;
    end
  end

`ifdef CLOCK_RECOVER_QUAD_EN
  logic [NCO_W-1:0] acc_q_reg;

  always_ff @(posedge clk) begin
    if (!reset) acc_q_reg <= PHASE_QUARTER;
    else        acc_q_reg <= acc_next + PHASE_QUARTER;
  end

  assign clk_q = acc_q_reg[NCO_W-1];
`else
  assign clk_q = 1'b0;
`endif

  assign clk_out   = acc_reg[NCO_W-1];
  assign freq_word = freq_word_reg;
  assign phase_err = phase_err_reg;
  assign locked    = (state_reg == LOCKED);
endmodule

// File: tb/tb_clock_recover.sv
// Self-checking bench for clock_recover: cycle-level arithmetic reference model
// plus directed scenario checks (lock, NOREF, saturation, reset, phase jump, quadrature).
`timescale 1ns/1ps
module tb_clock_recover;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ref_in = 1'b0;
  logic        clk_out, clk_q, locked;
  logic [15:0] freq_word, phase_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lock_cycles = 0;

  // reference model state (plain integers)
  localparam int ST_ACQ = 0, ST_LOCK = 1, ST_NOREF = 2;
  int m_acc, m_integ, m_freq, m_perr, m_state, m_ecnt, m_idle;
  bit samp[$];

  clock_recover dut (
    .clk       (clk),
    .reset     (reset),
    .ref_in    (ref_in),
    .clk_out   (clk_out),
    .clk_q     (clk_q),
    .freq_word (freq_word),
    .phase_err (phase_err),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int wrap16(input int x);
    return ((x % 65536) + 65536) % 65536;
  endfunction

  // One clk edge of the behavioural loop: edges seen 3 samples after ref rises.
  task automatic model_step(input bit r, input bit rn);
    bit ev, tol;
    int e, ni, sum, oldf;
    if (!rn) begin
      m_acc = 0; m_integ = 0; m_freq = 3640; m_perr = 0;
      m_state = ST_ACQ; m_ecnt = 0; m_idle = 0;
      samp.delete();
      repeat (3) samp.push_back(1'b0);
      return;
    end
    ev = samp[samp.size()-2] && !samp[samp.size()-3];
    samp.push_back(r);
    void'(samp.pop_front());
    if (ev && m_state == ST_NOREF) begin
      m_state = ST_ACQ; m_ecnt = 0; m_idle = 0;
      m_acc = wrap16(m_acc + m_freq);
    end else if (ev) begin
      e = m_acc - 32768;
      oldf = m_freq;
      m_perr = e;
      ni = m_integ - (e >>> 8);
      sum = 3640 + ni;
      if (sum > 4096)      begin m_freq = 4096; m_integ = 4096 - 3640; end
      else if (sum < 1024) begin m_freq = 1024; m_integ = 1024 - 3640; end
      else                 begin m_freq = sum;  m_integ = ni; end
      m_acc = wrap16(m_acc + oldf - (e >>> 3));
      tol = (e > -2048) && (e < 2048);
      m_idle = 0;
      if (m_state == ST_ACQ) begin
        if (tol) begin
          m_ecnt++;
          if (m_ecnt == 16) begin m_state = ST_LOCK; m_ecnt = 0; end
        end else m_ecnt = 0;
      end else begin
        if (!tol) begin
          m_ecnt++;
          if (m_ecnt == 4) begin m_state = ST_ACQ; m_ecnt = 0; end
        end else m_ecnt = 0;
      end
    end else begin
      m_acc = wrap16(m_acc + m_freq);
      if (m_state != ST_NOREF) begin
        m_idle++;
        if (m_idle == 256) begin m_state = ST_NOREF; m_ecnt = 0; end
      end
    end
  endtask

  task automatic check_all();
    chk("clk_out", 32'(clk_out), (m_acc >= 32768) ? 32'd1 : 32'd0);
    chk("freq_word", 32'(freq_word), 32'(m_freq));
    chk("phase_err", 32'(phase_err), 32'(m_perr) & 32'hFFFF);
    chk("locked", 32'(locked), (m_state == ST_LOCK) ? 32'd1 : 32'd0);
`ifdef CLOCK_RECOVER_QUAD_EN
    chk("clk_q", 32'(clk_q), (wrap16(m_acc + 16384) >= 32768) ? 32'd1 : 32'd0);
`else
    chk("clk_q", 32'(clk_q), 32'd0);
`endif
  endtask

  task automatic tick(input bit r, input bit rn);
    ref_in = r;
    reset  = rn;
    model_step(r, rn);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (locked) lock_cycles++;
    check_all();
  endtask

  task automatic edge_wave(input int period);
    int h;
    h = $urandom_range(1, period - 1);
    repeat (h) tick(1'b1, 1'b1);
    repeat (period - h) tick(1'b0, 1'b1);
  endtask

  // Times each ref edge from the model so the detected error lands in a chosen sign band.
  task automatic biased_edge(input bit push_up);
    int lo, hi, pa, n;
    lo = push_up ? 16'h1000 : 16'hA000;
    hi = push_up ? 16'h6000 : 16'hF000;
    n = 0;
    pa = wrap16(m_acc + 2 * m_freq);
    while (!(pa >= lo && pa <= hi) && n < 100) begin
      tick(1'b0, 1'b1);
      n++;
      pa = wrap16(m_acc + 2 * m_freq);
    end
    repeat (3) tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
  endtask

  initial begin
    int n, f0, ups, pe, last_out, q_seen;
    bit prev_out, prev_q;

    repeat (3) tick(1'b0, 1'b0);
    chk("rst_freq_word", 32'(freq_word), 32'd3640);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_phase_err", 32'(phase_err), 32'd0);
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_clk_q", 32'(clk_q), 32'd0);
    repeat ($urandom_range(0, 17)) tick(1'b0, 1'b1);

    // lock on an 18-clk reference
    n = 0;
    while (!locked && n < 400) begin edge_wave(18); n++; end
    chk("t1_lock_within_400", 32'(locked), 32'd1);
    repeat (200) edge_wave(18);
    for (int i = 0; i < 100; i++) begin
      edge_wave(18);
      pe = int'($signed(phase_err));
      chk("t1_perr_in_tol", 32'((pe > -2048) && (pe < 2048)), 32'd1);
    end
    chk("t1_freq_settle", 32'((freq_word >= 3638) && (freq_word <= 3644)), 32'd1);

    repeat (100) edge_wave($urandom_range(17, 19));
    repeat (200) edge_wave(18);
    chk("t2_locked_before_gap", 32'(locked), 32'd1);

    // reference disappears: NOREF, frozen word, NCO freewheels
    f0 = int'(freq_word);
    ups = 0;
    prev_out = clk_out;
    repeat (300) begin
      tick(1'b0, 1'b1);
      if (clk_out && !prev_out) ups++;
      prev_out = clk_out;
    end
    chk("t2_noref_unlocked", 32'(locked), 32'd0);
    chk("t2_freq_frozen", 32'(freq_word), 32'(f0));
    chk("t2_freewheel_toggles", 32'((ups >= 15) && (ups <= 18)), 32'd1);
    n = 0;
    while (!locked && n < 400) begin edge_wave(18); n++; end
    chk("t2_relock", 32'(locked), 32'd1);

    // quadrature relationship while locked
    last_out = -1;
    q_seen = 0;
    prev_out = clk_out;
    prev_q = clk_q;
    repeat (20) begin
      for (int i = 0; i < 18; i++) begin
        tick((i < 9) ? 1'b1 : 1'b0, 1'b1);
`ifdef CLOCK_RECOVER_QUAD_EN
        if (clk_q && !prev_q) last_out = cyc;
        if (clk_out && !prev_out && last_out >= 0) begin
          chk("t6_quarter_offset", 32'((cyc - last_out >= 3) && (cyc - last_out <= 6)), 32'd1);
          q_seen++;
        end
`else
        if (clk_q) q_seen++;
`endif
        prev_out = clk_out;
        prev_q = clk_q;
      end
    end
`ifdef CLOCK_RECOVER_QUAD_EN
    chk("t6_quad_edges_seen", 32'(q_seen >= 15), 32'd1);
`else
    chk("t6_clk_q_stays_low", 32'(q_seen), 32'd0);
`endif

    // half-period phase jump: lock drops after exactly four bad edges
    repeat (9) tick(1'b0, 1'b1);
    n = 0;
    while (locked && n < 20) begin edge_wave(18); n++; end
    chk("t5_loss_edges", 32'(n), 32'd4);
    n = 0;
    while (!locked && n < 400) begin edge_wave(18); n++; end
    chk("t5_relock", 32'(locked), 32'd1);

    // one-cycle reset while locked
    tick(1'b0, 1'b0);
    chk("t4_freq_word", 32'(freq_word), 32'd3640);
    chk("t4_locked", 32'(locked), 32'd0);
    chk("t4_phase_err", 32'(phase_err), 32'd0);
    chk("t4_clk_out", 32'(clk_out), 32'd0);

    // 9-clk reference: twice the nominal rate, never locks
    lock_cycles = 0;
    repeat (400) edge_wave(9);
    chk("t3_never_locked", 32'(lock_cycles), 32'd0);
    chk("t3_word_in_range", 32'((freq_word >= 1024) && (freq_word <= 4096)), 32'd1);

    // drive the word into both clamps, then recover on 18 clk
    repeat (200) biased_edge(1'b1);
    chk("t3_sat_high", 32'(freq_word), 32'd4096);
    repeat (200) biased_edge(1'b0);
    chk("t3_sat_low", 32'(freq_word), 32'd1024);
    chk("t3_biased_never_locked", 32'(lock_cycles), 32'd0);
    repeat (100) edge_wave(18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
